// File: rtl/e_tb_213_if.sv
// Handshake bundle for the e_tb_213 survivor memory / traceback unit.
// master = decision source + bit consumer side, slave = the traceback unit.
interface e_tb_213_if #(
  parameter int NS = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [NS-1:0] in_bx;
  logic [1:0]    in_end_state;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_last;
  logic          busy;

  modport master (
    output in_valid, in_bx, in_end_state, out_ready,
    input  in_ready, out_valid, out_bit, out_last, busy
  );

  modport slave (
    input  in_valid, in_bx, in_end_state, out_ready,
    output in_ready, out_valid, out_bit, out_last, busy
  );
endinterface

// File: rtl/e_tb_213.sv
// Survivor memory and traceback unit for the (2,1,3) backward-label Viterbi
// decoder. Buffers FRAME_LEN decision vectors, traces back from the end state
// and emits the decoded bits in forward order over a valid/ready handshake.
// Optional build macro E213_TAILBIT_EN: zero-terminated frames (traceback
// starts at state 00 and the two tail bits are not emitted).
module e_tb_213 #(
  parameter int FRAME_LEN = 16,
  parameter int PW        = 6
) (
  input  logic      clk,
  input  logic      reset,
  e_tb_213_if.slave bus
);

  localparam int NS = 4;
  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
`ifdef E213_TAILBIT_EN
  localparam int N_OUT = FRAME_LEN - 2;
`else
  localparam int N_OUT = FRAME_LEN;
`endif

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_TRACE = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] op_q, op_d;
  logic [1:0]    tb_state_q, tb_state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          out_bit_q, out_bit_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;

  logic [NS-1:0] mem [FRAME_LEN];
  logic          obuf [FRAME_LEN];
  logic          mem_we;
  logic          obuf_we;
  logic [NS-1:0] mem_rd;
  logic [PW-1:0] op_inc;
  logic [1:0]    start_state;

  assign mem_rd = mem[rd_ptr_q[AW-1:0]];
  assign op_inc = op_q + PW'(1);

`ifdef E213_TAILBIT_EN
  // Zero-terminated frames always end in state 00.
  assign start_state = 2'b00;
`else
  assign start_state = bus.in_end_state;
`endif

  // Next-state and output decode for FILL / TRACE / OUT.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    op_d        = op_q;
    tb_state_d  = tb_state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    mem_we      = 1'b0;
    obuf_we     = 1'b0;
    case (state_q)
      S_FILL: begin
        if (bus.in_valid) begin
          mem_we = 1'b1;
          if (wr_ptr_q == PW'(FRAME_LEN - 1)) begin
            wr_ptr_d   = {PW{1'b0}};
            rd_ptr_d   = PW'(FRAME_LEN - 1);
            tb_state_d = start_state;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
            state_d    = S_TRACE;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      S_TRACE: begin
        // Record the MSB of the current state, then step to its predecessor.
        obuf_we    = 1'b1;
        tb_state_d = {tb_state_q[0], mem_rd[tb_state_q]};
        if (rd_ptr_q == {PW{1'b0}}) begin
          op_d    = {PW{1'b0}};
          state_d = S_OUT;
        end else begin
          rd_ptr_d = rd_ptr_q - PW'(1);
        end
      end
      S_OUT: begin
        if (!out_valid_q) begin
          // First cycle in OUT: present bit 0 (obuf is fully written now).
          out_valid_d = 1'b1;
          out_bit_d   = obuf[op_q[AW-1:0]];
          out_last_d  = (op_q == PW'(N_OUT - 1));
        end else if (bus.out_ready) begin
          if (op_q == PW'(N_OUT - 1)) begin
            out_valid_d = 1'b0;
            out_bit_d   = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_FILL;
          end else begin
            op_d       = op_inc;
            out_bit_d  = obuf[op_inc[AW-1:0]];
            out_last_d = (op_inc == PW'(N_OUT - 1));
          end
        end else begin
          // Backpressure: everything holds.
          op_d = op_q;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // Control state and registered outputs, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      op_q        <= {PW{1'b0}};
      tb_state_q  <= 2'b00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      op_q        <= op_d;
      tb_state_q  <= tb_state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Decision memory and decoded-bit buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= bus.in_bx;
    end
    if (obuf_we) begin
      obuf[rd_ptr_q[AW-1:0]] <= tb_state_q[1];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_e_tb_213.sv
// Scoreboard bench for e_tb_213. dut_a runs the short directed frame
// (FRAME_LEN=4, or 6 with E213_TAILBIT_EN), dut_b runs 100 random
// back-to-back frames at FRAME_LEN=16.
module tb_e_tb_213;

`ifdef E213_TAILBIT_EN
  localparam int FLA  = 6;
  localparam int TAIL = 2;
`else
  localparam int FLA  = 4;
  localparam int TAIL = 0;
`endif
  localparam int FLB     = 16;
  localparam int NOB     = FLB - TAIL;
  localparam int NFRAMES = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_tb_213_if ifa ();
  e_tb_213_if ifb ();

  e_tb_213 #(.FRAME_LEN(FLA), .PW(6)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  e_tb_213 #(.FRAME_LEN(FLB), .PW(6)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int popa  = 0;
  int popb  = 0;
  int base_a = 0;
  logic [1:0] qa [$];
  logic [1:0] qb [$];
  logic [3:0] va [FLA];
  logic       eb [4];
  bit   hold_a = 1'b0;
  logic hb_a, hl_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // free-running cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor A: pops expectations on every handshake, checks hold under stall
  initial forever begin
    logic [1:0] e;
    @(negedge clk);
    if (reset) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        chk("hold_valid_a", 32'(ifa.out_valid), 32'd1);
        chk("hold_bit_a", 32'(ifa.out_bit), 32'(hb_a));
        chk("hold_last_a", 32'(ifa.out_last), 32'(hl_a));
      end
      hold_a = 1'b0;
      if (ifa.out_valid) begin
        chk("busy_a", 32'(ifa.busy), 32'd1);
        chk("in_ready_in_out_a", 32'(ifa.in_ready), 32'd0);
        if (ifa.out_ready) begin
          if (qa.size() == 0) begin
            chk("unexpected_out_a", 32'd1, 32'd0);
          end else begin
            e = qa.pop_front();
            chk("bit_a", 32'(ifa.out_bit), 32'(e[1]));
            chk("last_a", 32'(ifa.out_last), 32'(e[0]));
          end
          popa++;
        end else begin
          hold_a = 1'b1;
          hb_a   = ifa.out_bit;
          hl_a   = ifa.out_last;
        end
      end
    end
  end

  // monitor B
  initial forever begin
    logic [1:0] e;
    @(negedge clk);
    if (!reset && ifb.out_valid && ifb.out_ready) begin
      chk("in_ready_in_out_b", 32'(ifb.in_ready), 32'd0);
      if (qb.size() == 0) begin
        chk("unexpected_out_b", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("bit_b", 32'(ifb.out_bit), 32'(e[1]));
        chk("last_b", 32'(ifb.out_last), 32'(e[0]));
      end
      popb++;
    end
  end

  task automatic send(input bit b, input logic [3:0] bx, input logic [1:0] es,
                      input int gap, output int acc);
    bit ok = 1'b0;
    if (b) begin
      ifb.in_valid = 1'b1; ifb.in_bx = bx; ifb.in_end_state = es;
    end else begin
      ifa.in_valid = 1'b1; ifa.in_bx = bx; ifa.in_end_state = es;
    end
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = b ? ifb.in_ready : ifa.in_ready;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    if (b) ifb.in_valid = 1'b0;
    else   ifa.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // push the expected 1,0,1,1 and feed the directed frame into dut_a
  task automatic run_a(input int gap, output int acc);
    base_a = popa;
    for (int i = 0; i < 4; i++) qa.push_back({eb[i], (i == 3) ? 1'b1 : 1'b0});
    for (int t = 0; t < FLA; t++) send(1'b0, va[t], 2'b11, gap, acc);
  endtask

  task automatic drain_a(input bit stall);
    int  stalls = 0;
    bit  done   = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk); #1;
      if (popa >= base_a + 4) done = 1'b1;
      else if (stall && ifa.out_valid && (popa - base_a) == 2 && stalls < 3) begin
        ifa.out_ready = 1'b0;
        stalls++;
      end else ifa.out_ready = 1'b1;
    end
    ifa.out_ready = 1'b1;
    chk("drain_a_done", 32'(done), 32'd1);
    chk("in_ready_after_last", 32'(ifa.in_ready), 32'd1);
    chk("out_valid_after_last", 32'(ifa.out_valid), 32'd0);
    chk("busy_after_last", 32'(ifa.busy), 32'd0);
    if (stall) chk("stall_cycles", 32'(stalls), 32'd3);
  endtask

  initial begin
    int acc;
    int seen;
    bit got;
    logic [1:0] s, n;
    logic [3:0] bx;
    logic       u [FLB];

`ifdef E213_TAILBIT_EN
    va = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0001};
`else
    va = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
`endif
    eb = '{1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_bx = 4'h0; ifa.in_end_state = 2'b00; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_bx = 4'h0; ifb.in_end_state = 2'b00; ifb.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_out_bit", 32'(ifa.out_bit), 32'd0);
    chk("rst_out_last", 32'(ifa.out_last), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_in_ready_b", 32'(ifb.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 1: single frame with latency check
    run_a(0, acc);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = ifa.out_valid;
    end
    chk("latency", 32'(cyc - acc), 32'(FLA + 1));
    drain_a(1'b0);

    // 2: backpressure on bit index 2
    run_a(0, acc);
    drain_a(1'b1);

    // 3: in_valid toggling during FILL, then held high during TRACE
    run_a(1, acc);
    ifa.in_valid = 1'b1; ifa.in_bx = 4'hF;
    for (int k = 0; k < FLA; k++) begin
      chk("in_ready_trace", 32'(ifa.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    ifa.in_valid = 1'b0;
    drain_a(1'b0);
    run_a(0, acc);
    drain_a(1'b0);

    // 4: async reset pulse mid-TRACE
    for (int t = 0; t < FLA; t++) send(1'b0, va[t], 2'b11, 0, acc);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("mid_rst_busy", 32'(ifa.busy), 32'd0);
    chk("mid_rst_out_last", 32'(ifa.out_last), 32'd0);
    chk("mid_rst_out_bit", 32'(ifa.out_bit), 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (2 * FLA + 6) begin
      @(negedge clk);
      if (ifa.out_valid) seen++;
    end
    chk("no_out_after_reset", 32'(seen), 32'd0);
    @(posedge clk); #1;
    run_a(0, acc);
    drain_a(1'b0);

    // 6: back-to-back random frames on dut_b
    for (int f = 0; f < NFRAMES; f++) begin
      for (int t = 0; t < FLB; t++) u[t] = (t >= FLB - TAIL) ? 1'b0 : 1'($urandom_range(1, 0));
      for (int t = 0; t < NOB; t++) qb.push_back({u[t], (t == NOB - 1) ? 1'b1 : 1'b0});
      s = 2'b00;
      for (int t = 0; t < FLB; t++) begin
        n = {u[t], s[1]};
        bx = 4'($urandom);
        bx[n] = s[0];
        s = n;
        if (t == FLB - 1)
          send(1'b1, bx, (TAIL != 0) ? 2'b11 : s, 0, acc);
        else
          send(1'b1, bx, 2'b00, 0, acc);
      end
    end
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(posedge clk); #1;
      got = (popb >= NFRAMES * NOB);
    end
    chk("drain_b_done", 32'(popb), 32'(NFRAMES * NOB));
    repeat (4) @(posedge clk);
    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/e_tb_213.md
Name: e_tb_213

Overview:
- Survivor memory and traceback unit for the (2,1,3) backward-label Viterbi decoder.
- Sits directly downstream of the four ACS blocks and consumes one 4-bit vector of backward-label selects per trellis step (one bit per state).
- Buffers a fixed-length frame, traces back from a chosen end state, and emits the decoded bits in forward order with a valid/ready handshake.

Parameters:
- FRAME_LEN, 16, trellis steps per frame (decision vectors buffered, legal range 4..64).
- NS, 4, number of trellis states (2^(K-1), K=3); fixed, not to be overridden.
- PW, 6, pointer width; must satisfy 2^PW >= FRAME_LEN.

Ports:
- clk  input  1  decoder clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  decision vector present.
- in_ready  output  1  block can accept a decision vector.
- in_bx  input  NS  backward-label selects for this step. Bit s is the select for state s: 0 = upper path, 1 = lower path.
- in_end_state  input  2  traceback start state; sampled only on the accept of step FRAME_LEN-1.
- out_valid  output  1  decoded bit present.
- out_ready  input  1  consumer accepts out_bit.
- out_bit  output  1  decoded information bit.
- out_last  output  1  marks the final decoded bit of the frame.
- busy  output  1  high in TRACE or OUT.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0. State=FILL, wr_ptr=0, tb_state=0.
- Reset has the same effect mid-frame: the partial frame is discarded and no further output is produced for it.
- Trellis convention: state {s1,s0}, where s1 is the newest input. Next state = {u,s1}.
  - Predecessor of state {a,b} = {b, in_bx[{a,b}]}.
  - Decoded bit at a step = MSB of the state reached at that step.
- FILL:
  - in_ready=1. On in_valid&in_ready, mem[wr_ptr] <= in_bx and wr_ptr increments.
  - On the accept at wr_ptr==FRAME_LEN-1: tb_state <= in_end_state, rd_ptr <= FRAME_LEN-1, wr_ptr <= 0, go to TRACE.
- TRACE:
  - in_ready=0, busy=1. Exactly FRAME_LEN cycles, one step per cycle.
  - Each cycle: obuf[rd_ptr] <= tb_state[1]; tb_state <= {tb_state[0], mem[rd_ptr][tb_state]}; rd_ptr decrements.
  - After the rd_ptr==0 step: go to OUT with op=0.
- OUT:
  - in_ready=0, busy=1. out_valid=1, out_bit=obuf[op], out_last=(op==N_OUT-1).
  - Outputs are registered and hold stable while out_valid&!out_ready.
  - On out_valid&out_ready: op increments. After the last bit: out_valid=0, out_last=0, return to FILL. The first in_ready=1 appears on the cycle after the last handshake.
- Latency: first out_valid is asserted FRAME_LEN+1 cycles after the clock edge that accepts step FRAME_LEN-1.
- Throughput: one bit per cycle in OUT when out_ready is held high.
- in_valid outside FILL is ignored (not stored, not an error); upstream must hold data until in_ready.
- N_OUT = FRAME_LEN, except as modified by the optional feature below.

Optional Feature:
- Macro: E213_TAILBIT_EN.
- Defined (zero-terminated frames):
  - in_end_state is ignored; traceback always starts at state 2'b00.
  - The last K-1=2 steps are tail bits and are not output: N_OUT = FRAME_LEN-2, out_last on obuf[FRAME_LEN-3].
  - TRACE length is unchanged (FRAME_LEN cycles).
- Undefined: traceback starts from in_end_state; N_OUT = FRAME_LEN.

Test Plan:
1. Single frame, FRAME_LEN=4, macro undefined. in_bx = 4'b0000, 4'b0000, 4'b0100, 4'b0000, in_end_state=2'b11 → out_bit sequence 1,0,1,1; out_last on the 4th bit; first out_valid 5 cycles after the 4th accept.
2. Backpressure: same frame with out_ready low for 3 cycles at bit 2 → out_bit=1 held stable with out_valid=1; sequence unchanged; in_ready stays 0 until after the last handshake.
3. Input stalls: in_valid toggles 1,0,1,0 during FILL → only the cycles with in_valid=1 are stored; result identical to scenario 1. in_valid=1 during TRACE/OUT is not stored.
4. Reset mid-TRACE (async pulse between edges) → outputs go to reset values immediately, with no out_valid. A following clean frame decodes correctly as in scenario 1.
5. E213_TAILBIT_EN defined, FRAME_LEN=6, encode u=1,0,1,1,0,0 from state 00, with the matching select vectors and in_end_state=2'b11 (deliberately wrong) → out_bit 1,0,1,1; out_last on the 4th bit.
6. Back-to-back frames, FRAME_LEN=16, random u with correct selects, out_ready=1 → decoded bits match u exactly over 100 frames; no bit dropped or duplicated at frame boundaries.
